// File: rtl/l1_refill_ctrl.sv
// L1 data-cache refill and write-through controller: services read misses with a
// single-word downstream read and drains CPU stores in order through a small FIFO.
module l1_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [3:0]            byte_en_i,
    input  logic                  l1_cache_hit_i,
    output logic                  l2_cache_valid_o,
    output logic [DATA_WIDTH-1:0] l2_cache_data_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned BE_W  = 4;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, FILL} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [BE_W-1:0]       be;
    } wb_entry_t;

    state_t state, state_d;

    wb_entry_t      wb_mem [WB_DEPTH];
    wb_entry_t      wb_head;
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           wb_empty, wb_full, push, pop, rd_miss;
    logic [ADDR_WIDTH-1:0] word_addr;

    logic                  req_d, we_d, valid_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, fill_d;
    logic [BE_W-1:0]       be_d;

    assign word_addr = addr_i & WORD_MASK;
    assign rd_miss   = rd_en_i && !l1_cache_hit_i;
    assign wb_empty  = (wr_ptr == rd_ptr);
    assign wb_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push      = wr_en_i && !wb_full;
    assign pop       = (state == WR_REQ) && mem_ack_i;
    assign wb_head   = wb_mem[rd_ptr[PTR_W-1:0]];

    // Stall until the fill word is on its way, or while a store cannot be queued.
    assign stall_o = (rd_miss && (state != FILL)) || (wr_en_i && wb_full);

    // Write-buffer storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_mem[wr_ptr[PTR_W-1:0]] <= '{addr: word_addr, data: wr_data_i, be: byte_en_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Next state and next registered outputs; buffered stores always go before a miss.
    always_comb begin
        state_d = state;
        req_d   = mem_req_o;
        we_d    = mem_we_o;
        addr_d  = mem_addr_o;
        wdata_d = mem_wdata_o;
        be_d    = mem_be_o;
        valid_d = 1'b0;
        fill_d  = l2_cache_data_o;
        case (state)
            IDLE: begin
                if (!wb_empty) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = wb_head.addr;
                    wdata_d = wb_head.data;
                    be_d    = wb_head.be;
                    state_d = WR_REQ;
                end else if (rd_miss && !wr_en_i) begin
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = word_addr;
                    wdata_d = '0;
                    be_d    = '0;
                    state_d = RD_REQ;
                end
            end
            WR_REQ: begin
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    fill_d  = mem_rdata_i;
                    valid_d = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            mem_req_o        <= 1'b0;
            mem_we_o         <= 1'b0;
            mem_addr_o       <= '0;
            mem_wdata_o      <= '0;
            mem_be_o         <= '0;
            l2_cache_valid_o <= 1'b0;
            l2_cache_data_o  <= '0;
        end else begin
            state            <= state_d;
            mem_req_o        <= req_d;
            mem_we_o         <= we_d;
            mem_addr_o       <= addr_d;
            mem_wdata_o      <= wdata_d;
            mem_be_o         <= be_d;
            l2_cache_valid_o <= valid_d;
            l2_cache_data_o  <= fill_d;
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl: read misses, wait states, write ordering,
// buffer-full stall, simultaneous push/pop and reset during a miss.
module tb_l1_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en_i, wr_en_i, l1_cache_hit_i, mem_ack_i;
    logic [31:0] addr_i, wr_data_i, mem_rdata_i;
    logic [3:0]  byte_en_i;
    logic        l2_cache_valid_o, stall_o, mem_req_o, mem_we_o;
    logic [31:0] l2_cache_data_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l1_refill_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WB_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .rd_en_i(rd_en_i), .wr_en_i(wr_en_i), .addr_i(addr_i),
        .wr_data_i(wr_data_i), .byte_en_i(byte_en_i), .l1_cache_hit_i(l1_cache_hit_i),
        .l2_cache_valid_o(l2_cache_valid_o), .l2_cache_data_o(l2_cache_data_o),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven, outputs sampled.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 10 && !mem_req_o; i++) step();
        chk({tag, "_req"},   32'(mem_req_o), 32'd1);
        chk({tag, "_we"},    32'(mem_we_o), 32'd1);
        chk({tag, "_addr"},  mem_addr_o, a);
        chk({tag, "_wdata"}, mem_wdata_o, d);
        chk({tag, "_be"},    32'(mem_be_o), 32'(be));
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        chk({tag, "_req_drop"}, 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rd_en_i = 0; wr_en_i = 0; l1_cache_hit_i = 0; mem_ack_i = 0;
        addr_i = '0; wr_data_i = '0; mem_rdata_i = '0; byte_en_i = '0;
        step(); step();
        chk("rst_req",   32'(mem_req_o), 0);
        chk("rst_we",    32'(mem_we_o), 0);
        chk("rst_addr",  mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_be",    32'(mem_be_o), 0);
        chk("rst_valid", 32'(l2_cache_valid_o), 0);
        chk("rst_data",  l2_cache_data_o, 0);
        chk("rst_stall", 32'(stall_o), 0);
        rst = 1'b0;
        step();

        // Read miss, immediate ack
        rd_en_i = 1; l1_cache_hit_i = 0; addr_i = 32'h0000_1006;
        #1 chk("miss_c0_stall", 32'(stall_o), 1);
        step();
        chk("miss_c1_req",   32'(mem_req_o), 1);
        chk("miss_c1_we",    32'(mem_we_o), 0);
        chk("miss_c1_addr",  mem_addr_o, 32'h0000_1004);
        chk("miss_c1_be",    32'(mem_be_o), 0);
        chk("miss_c1_stall", 32'(stall_o), 1);
        mem_ack_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
        step();
        mem_ack_i = 0;
        chk("miss_c2_valid", 32'(l2_cache_valid_o), 1);
        chk("miss_c2_data",  l2_cache_data_o, 32'hDEAD_BEEF);
        chk("miss_c2_stall", 32'(stall_o), 0);
        chk("miss_c2_req",   32'(mem_req_o), 0);
        rd_en_i = 0;
        step();
        chk("miss_c3_valid", 32'(l2_cache_valid_o), 0);

        // Read miss with 3 wait states
        rd_en_i = 1; addr_i = 32'h0000_1006;
        step();
        for (int i = 1; i <= 4; i++) begin
            chk("wait_req",   32'(mem_req_o), 1);
            chk("wait_addr",  mem_addr_o, 32'h0000_1004);
            chk("wait_stall", 32'(stall_o), 1);
            chk("wait_valid", 32'(l2_cache_valid_o), 0);
            if (i == 4) begin
                mem_ack_i = 1; mem_rdata_i = 32'hCAFE_F00D;
            end
            step();
        end
        mem_ack_i = 0;
        chk("wait_fill_valid", 32'(l2_cache_valid_o), 1);
        chk("wait_fill_data",  l2_cache_data_o, 32'hCAFE_F00D);
        rd_en_i = 0;
        step();
        chk("wait_pulse_end", 32'(l2_cache_valid_o), 0);

        // Write then read miss to the same address: write must go first
        wr_en_i = 1; addr_i = 32'h200; wr_data_i = 32'h1111_2222; byte_en_i = 4'b0011;
        #1 chk("ord_store_stall", 32'(stall_o), 0);
        step();
        wr_en_i = 0; rd_en_i = 1; l1_cache_hit_i = 0;
        #1 chk("ord_rd_stall", 32'(stall_o), 1);
        chk("ord_no_req_yet", 32'(mem_req_o), 0);
        step();
        chk("ord_first_we", 32'(mem_we_o), 1);
        expect_write("ord_wr", 32'h200, 32'h1111_2222, 4'b0011);
        step();
        chk("ord_rd_req",  32'(mem_req_o), 1);
        chk("ord_rd_we",   32'(mem_we_o), 0);
        chk("ord_rd_addr", mem_addr_o, 32'h200);
        chk("ord_rd_be",   32'(mem_be_o), 0);
        mem_ack_i = 1; mem_rdata_i = 32'h1111_2222;
        step();
        mem_ack_i = 0;
        chk("ord_fill", l2_cache_data_o, 32'h1111_2222);
        rd_en_i = 0;
        step();

        // Buffer full: 5 stores with ack held low
        wr_en_i = 1; byte_en_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            addr_i = 32'h300 + 32'(4 * i); wr_data_i = 32'hA000_0000 + 32'(i);
            #1 chk("full_store_stall", 32'(stall_o), 0);
            step();
        end
        addr_i = 32'h310; wr_data_i = 32'hA000_0004;
        #1 chk("full_5th_stall", 32'(stall_o), 1);
        chk("full_head_req",  32'(mem_req_o), 1);
        chk("full_head_addr", mem_addr_o, 32'h300);
        chk("full_head_data", mem_wdata_o, 32'hA000_0000);
        mem_ack_i = 1;
        step();
        mem_ack_i = 0;
        #1 chk("full_5th_accept_stall", 32'(stall_o), 0);
        step();
        wr_en_i = 0;
        for (int i = 1; i < 5; i++)
            expect_write("full_drain", 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        step(); step();
        chk("full_drained", 32'(mem_req_o), 0);

        // Store arriving in the same cycle as a write ack
        wr_en_i = 1; addr_i = 32'h400; wr_data_i = 32'h55; byte_en_i = 4'hF;
        step();
        wr_en_i = 0;
        step();
        chk("pp_x_req",  32'(mem_req_o), 1);
        chk("pp_x_addr", mem_addr_o, 32'h400);
        chk("pp_x_data", mem_wdata_o, 32'h55);
        mem_ack_i = 1; wr_en_i = 1; addr_i = 32'h404; wr_data_i = 32'h66; byte_en_i = 4'hC;
        #1 chk("pp_stall", 32'(stall_o), 0);
        step();
        mem_ack_i = 0; wr_en_i = 0;
        chk("pp_idle_req", 32'(mem_req_o), 0);
        expect_write("pp_y", 32'h404, 32'h66, 4'hC);
        step(); step();
        chk("pp_empty_after", 32'(mem_req_o), 0);

        // Reset during RD_REQ with a store queued behind it
        rd_en_i = 1; l1_cache_hit_i = 0; addr_i = 32'h0000_0808;
        step();
        chk("rm_req", 32'(mem_req_o), 1);
        rd_en_i = 0; wr_en_i = 1; addr_i = 32'h500; wr_data_i = 32'h77; byte_en_i = 4'hF;
        step();
        wr_en_i = 0;
        #1 rst = 1'b1;
        #1 chk("rm_async_req", 32'(mem_req_o), 0);
        chk("rm_async_we", 32'(mem_we_o), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rm_no_req",   32'(mem_req_o), 0);
            chk("rm_no_valid", 32'(l2_cache_valid_o), 0);
            step();
        end
        chk("rm_stall", 32'(stall_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l1_refill_ctrl.md
# l1_refill_ctrl

Miss and write-through controller between the L1 data cache and the next memory level (unified L2 / main-memory port). On an L1 read miss it issues a word read downstream and returns the word to L1 on `l2_cache_valid_o` / `l2_cache_data_o` for a single cycle. Every CPU store is also queued in a small write-through buffer and drained to memory in order. `stall_o` freezes the pipeline while a miss is outstanding or the buffer is full.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: word width. Fixed at 32 because of the 4-bit byte enable.
- `WB_DEPTH`, default 4: write-buffer entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rd_en_i`  in  1  CPU load this cycle.
- `wr_en_i`  in  1  CPU store this cycle.
- `addr_i`  in  ADDR_WIDTH  CPU byte address. Held stable by the CPU while `stall_o` = 1.
- `wr_data_i`  in  DATA_WIDTH  store data.
- `byte_en_i`  in  4  store byte lanes.
- `l1_cache_hit_i`  in  1  L1 hit flag for `addr_i`, same cycle.
- `l2_cache_valid_o`  out  1  fill-word valid to L1, one-cycle pulse.
- `l2_cache_data_o`  out  DATA_WIDTH  fill word to L1.
- `stall_o`  out  1  pipeline stall.
- `mem_req_o`  out  1  downstream request.
- `mem_we_o`  out  1  1 = write, 0 = read.
- `mem_addr_o`  out  ADDR_WIDTH  word-aligned address; bits [1:0] = 0.
- `mem_wdata_o`  out  DATA_WIDTH  write data.
- `mem_be_o`  out  4  write byte lanes. 4'b0000 on reads.
- `mem_ack_i`  in  1  downstream completion. Read data is valid in the same cycle.
- `mem_rdata_i`  in  DATA_WIDTH  read data.

## Operation
**State machine.** States are IDLE, WR_REQ, RD_REQ, FILL. State and all `mem_*` outputs are registered.

**IDLE**
- If the buffer is non-empty: load the head entry onto the `mem_*` outputs with `mem_req_o` = 1 and `mem_we_o` = 1, then go to WR_REQ.
- Else if `rd_en_i` && !`l1_cache_hit_i`: latch `{addr_i[31:2], 2'b00}`, drive `mem_req_o` = 1 and `mem_we_o` = 0, then go to RD_REQ.
- Buffered writes always go before a read miss. This preserves memory ordering, so read-after-write through memory is correct.

**WR_REQ**
- Hold all `mem_*` outputs until `mem_ack_i`.
- On ack: pop the head, deassert `mem_req_o`, go to IDLE.

**RD_REQ**
- Hold the request until `mem_ack_i`.
- On ack: capture `mem_rdata_i` into the fill register, deassert `mem_req_o`, go to FILL.

**FILL**
- `l2_cache_valid_o` = 1 and `l2_cache_data_o` = fill register, for exactly one cycle.
- Then go to IDLE.

**Write buffer**
- FIFO of `{addr, data, be}` with `WB_DEPTH` entries and wrapping pointers.
- Full and empty are distinguished by an extra pointer bit.
- On `wr_en_i` while not full: enqueue at the clock edge.
- A store is accepted in any state, including WR_REQ and RD_REQ.
- Simultaneous push and pop in the same cycle are both performed; occupancy is unchanged.
- The CPU holds the store while stalled, so a store is enqueued exactly once. This is enforced by the stall rule below.

**stall_o (combinational)**
- Asserted when any of the following holds:
  - (`rd_en_i` && !`l1_cache_hit_i` && state ≠ FILL);
  - (`wr_en_i` && buffer full).
- `rd_en_i` && `wr_en_i` together is illegal. `wr_en_i` takes priority and no read miss is started.

**Reset mid-operation.** Asynchronous reset returns to IDLE, empties the buffer, and drops any request. Downstream must discard an abandoned transaction.

**Reset values.** Every output is 0: `l2_cache_valid_o`, `l2_cache_data_o`, `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`. `stall_o` is 0 while inputs are idle.

## Timing
- **Read miss, zero-wait memory (ack in the first request cycle):**
  - cycle 0: miss seen, `stall_o` = 1.
  - cycle 1: `mem_req_o` = 1, ack arrives.
  - cycle 2: FILL. `l2_cache_valid_o` = 1, `stall_o` = 0. L1 forwards the word to the CPU and allocates it.
  - Penalty: 2 stall cycles, plus 1 per memory wait cycle, plus the drain time of any buffered writes.
- **Store to memory:** `wr_en_i` at cycle 0 enqueues at the edge. `mem_req_o` rises at cycle 2 if the FSM was IDLE.
- **Memory handshake:** `mem_req_o` and its address, data and byte enables are stable from assertion until the cycle `mem_ack_i` = 1 inclusive. `mem_ack_i` while `mem_req_o` = 0 is ignored.
- **Back-to-back writes:** at most one transaction per 2 cycles, because the FSM passes through IDLE between transactions.

## Test plan
- **Read miss, ack immediate.** Reset, then `rd_en_i` = 1, hit = 0, addr 0x0000_1006. Expect: `mem_addr_o` = 0x0000_1004 with req 1 and we 0 at cycle 1; mem returns 0xDEAD_BEEF; `l2_cache_valid_o` pulse with 0xDEAD_BEEF at cycle 2. `stall_o` = 1 at cycles 0–1 and 0 at cycle 2.
- **Wait states.** Same read as above, ack delayed 3 cycles. Expect `mem_addr_o` stable and req held for 4 cycles, then a single valid pulse.
- **Write ordering.** Store 0x1111_2222, be 4'b0011, to 0x200, then an immediate read miss on 0x200. Expect the write transaction (be 0011) to complete before any read request is issued.
- **Buffer full.** 5 back-to-back stores with memory ack held at 0 and `WB_DEPTH` = 4. Expect `stall_o` = 1 on the 5th store. After one ack the 5th store is enqueued. Memory sees all 5 writes in order.
- **Simultaneous push/pop.** A store arrives in the same cycle as a WR_REQ ack. Expect occupancy unchanged and both entries correct.
- **Reset mid-miss.** Assert `rst` during RD_REQ. Expect `mem_req_o` = 0 asynchronously, no valid pulse, and the buffer empty.
